// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the 3-stage core hazard controller: mux selects,
// writeback sources and FSM states.
package hazard_ctrl_pkg;

  localparam logic [1:0] REG1_MUX_REG = 2'd0;
  localparam logic [1:0] REG1_MUX_WB  = 2'd1;
  localparam logic [1:0] REG1_MUX_PC  = 2'd2;

  localparam logic [1:0] REG2_MUX_REG = 2'd0;
  localparam logic [1:0] REG2_MUX_WB  = 2'd1;
  localparam logic [1:0] REG2_MUX_IMM = 2'd2;

  localparam logic [1:0] PC_PLUS   = 2'd0;
  localparam logic [1:0] PC_JAL    = 2'd1;
  localparam logic [1:0] PC_BRANCH = 2'd2;

  localparam logic [1:0] WB_NONE = 2'd0;
  localparam logic [1:0] WB_ALU  = 2'd1;
  localparam logic [1:0] WB_MEM  = 2'd2;
  localparam logic [1:0] WB_PC   = 2'd3;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_e;

endpackage

// File: rtl/hazard_ctrl_if.sv
// EX-stage decode info into the hazard controller and the mux/stall
// controls back out to the datapath.
interface hazard_ctrl_if #(
  parameter int XREG_W = 5
);
  logic              ex_valid;
  logic [XREG_W-1:0] ex_rs1;
  logic [XREG_W-1:0] ex_rs2;
  logic              ex_use_rs1;
  logic              ex_use_rs2;
  logic              ex_op1_pc;
  logic              ex_op2_imm;
  logic [XREG_W-1:0] ex_rd;
  logic              ex_reg_we;
  logic              ex_is_load;
  logic              ex_is_jump;
  logic [1:0]        ex_wb_src;
  logic              ex_br_taken;
  logic              mem_busy;

  logic [1:0]        pc_sel;
  logic [1:0]        reg1_sel;
  logic [1:0]        reg2_sel;
  logic [1:0]        wb_sel;
  logic              pc_stall;
  logic              ex_kill;
  logic              wb_kill;

  modport master (
    output ex_valid, ex_rs1, ex_rs2, ex_use_rs1, ex_use_rs2, ex_op1_pc,
           ex_op2_imm, ex_rd, ex_reg_we, ex_is_load, ex_is_jump, ex_wb_src,
           ex_br_taken, mem_busy,
    input  pc_sel, reg1_sel, reg2_sel, wb_sel, pc_stall, ex_kill, wb_kill
  );

  modport slave (
    input  ex_valid, ex_rs1, ex_rs2, ex_use_rs1, ex_use_rs2, ex_op1_pc,
           ex_op2_imm, ex_rd, ex_reg_we, ex_is_load, ex_is_jump, ex_wb_src,
           ex_br_taken, mem_busy,
    output pc_sel, reg1_sel, reg2_sel, wb_sel, pc_stall, ex_kill, wb_kill
  );

endinterface

// File: rtl/hazard_cmp.sv
// Does the instruction in WB write the given source register? x0 never matches.
module hazard_cmp #(
  parameter int XREG_W = 5
) (
  input  logic              wb_valid_i,
  input  logic              wb_we_i,
  input  logic [XREG_W-1:0] wb_rd_i,
  input  logic [XREG_W-1:0] rs_i,
  output logic              hit_o
);

  assign hit_o = wb_valid_i && wb_we_i && (wb_rd_i != '0) && (wb_rd_i == rs_i);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: forwarding from WB, one-bubble load-use stall,
// branch/jump fetch kill and a global freeze while memory is busy.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int XREG_W = 5
) (
  input logic          clk,
  input logic          rst,
  hazard_ctrl_if.slave bus
);

  state_e            state_q;
  logic              wb_valid_q;
  logic [XREG_W-1:0] wb_rd_q;
  logic              wb_we_q;
  logic              wb_load_q;
  logic [1:0]        wb_src_q;
  logic              init_q;

  logic hz_rs1;
  logic hz_rs2;
  logic lu;

  hazard_cmp #(.XREG_W(XREG_W)) u_cmp_rs1 (
    .wb_valid_i (wb_valid_q),
    .wb_we_i    (wb_we_q),
    .wb_rd_i    (wb_rd_q),
    .rs_i       (bus.ex_rs1),
    .hit_o      (hz_rs1)
  );

  hazard_cmp #(.XREG_W(XREG_W)) u_cmp_rs2 (
    .wb_valid_i (wb_valid_q),
    .wb_we_i    (wb_we_q),
    .wb_rd_i    (wb_rd_q),
    .rs_i       (bus.ex_rs2),
    .hit_o      (hz_rs2)
  );

  // Load data is never forwarded into EX; a dependent instruction waits a cycle instead.
  assign lu = (state_q == RUN) && bus.ex_valid && wb_load_q &&
              ((bus.ex_use_rs1 && hz_rs1) || (bus.ex_use_rs2 && hz_rs2));

  always_comb begin
    bus.pc_sel   = PC_PLUS;
    bus.reg1_sel = REG1_MUX_REG;
    bus.reg2_sel = REG2_MUX_REG;
    bus.wb_sel   = wb_valid_q ? wb_src_q : WB_NONE;
    bus.pc_stall = 1'b0;
    bus.ex_kill  = init_q;
    bus.wb_kill  = 1'b0;
    if (rst) begin
      bus.wb_sel  = WB_NONE;
      bus.ex_kill = 1'b1;
    end else begin
      if (state_q == RUN) begin
        if (bus.ex_op1_pc)
          bus.reg1_sel = REG1_MUX_PC;
        else if (bus.ex_use_rs1 && hz_rs1 && !wb_load_q)
          bus.reg1_sel = REG1_MUX_WB;

        if (bus.ex_op2_imm)
          bus.reg2_sel = REG2_MUX_IMM;
        else if (bus.ex_use_rs2 && hz_rs2 && !wb_load_q)
          bus.reg2_sel = REG2_MUX_WB;

        if (lu) begin
          bus.pc_stall = 1'b1;
          bus.wb_kill  = 1'b1;
        end else if (bus.ex_valid && bus.ex_is_jump) begin
          bus.pc_sel  = PC_JAL;
          bus.ex_kill = 1'b1;
        end else if (bus.ex_valid && bus.ex_br_taken) begin
          bus.pc_sel  = PC_BRANCH;
          bus.ex_kill = 1'b1;
        end
      end
      // A busy memory freezes everything, so nothing may be killed this cycle.
      if (bus.mem_busy) begin
        bus.pc_stall = 1'b1;
        bus.ex_kill  = 1'b0;
        bus.wb_kill  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_we_q    <= 1'b0;
      wb_load_q  <= 1'b0;
      wb_src_q   <= WB_NONE;
      init_q     <= 1'b1;
    end else if (!bus.mem_busy) begin
      case (state_q)
        RUN:     if (lu) state_q <= STALL;
        STALL:   state_q <= RUN;
        default: state_q <= RUN;
      endcase
      wb_valid_q <= bus.ex_valid && !lu;
      wb_rd_q    <= bus.ex_rd;
      wb_we_q    <= bus.ex_reg_we;
      wb_load_q  <= bus.ex_is_load;
      wb_src_q   <= bus.ex_wb_src;
      init_q     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl: each cycle's stimulus pushes its
// hand-computed expected outputs; a negedge monitor pops and compares.
module tb_hazard_ctrl;

  typedef struct {
    logic       v;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic       op1pc;
    logic       op2imm;
    logic [4:0] rd;
    logic       we;
    logic       ld;
    logic       jmp;
    logic       br;
    logic [1:0] src;
  } stim_t;

  typedef struct {
    string      name;
    logic [1:0] pc;
    logic [1:0] r1;
    logic [1:0] r2;
    logic [1:0] wb;
    logic       st;
    logic       exk;
    logic       wbk;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  exp_t expQ[$];

  hazard_ctrl_if #(.XREG_W(5)) hif ();

  hazard_ctrl #(.XREG_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (hif)
  );

  always #5 clk = ~clk;

  function automatic stim_t mk(logic v, logic [4:0] rs1, logic u1, logic [4:0] rs2,
                               logic u2, logic op1pc, logic op2imm, logic [4:0] rd,
                               logic we, logic ld, logic jmp, logic br, logic [1:0] src);
    stim_t s;
    s.v = v; s.rs1 = rs1; s.u1 = u1; s.rs2 = rs2; s.u2 = u2;
    s.op1pc = op1pc; s.op2imm = op2imm; s.rd = rd; s.we = we;
    s.ld = ld; s.jmp = jmp; s.br = br; s.src = src;
    return s;
  endfunction

  function automatic exp_t ex(string n, logic [1:0] pc, logic [1:0] r1, logic [1:0] r2,
                              logic [1:0] wb, logic st, logic exk, logic wbk);
    exp_t e;
    e.name = n; e.pc = pc; e.r1 = r1; e.r2 = r2; e.wb = wb;
    e.st = st; e.exk = exk; e.wbk = wbk;
    return e;
  endfunction

  task automatic driveInputs(input logic r, input logic busy, input stim_t s);
    rst             = r;
    hif.mem_busy    = busy;
    hif.ex_valid    = s.v;
    hif.ex_rs1      = s.rs1;
    hif.ex_use_rs1  = s.u1;
    hif.ex_rs2      = s.rs2;
    hif.ex_use_rs2  = s.u2;
    hif.ex_op1_pc   = s.op1pc;
    hif.ex_op2_imm  = s.op2imm;
    hif.ex_rd       = s.rd;
    hif.ex_reg_we   = s.we;
    hif.ex_is_load  = s.ld;
    hif.ex_is_jump  = s.jmp;
    hif.ex_br_taken = s.br;
    hif.ex_wb_src   = s.src;
  endtask

  task automatic applyStimulus(input logic r, input logic busy, input stim_t s, input exp_t e);
    @(posedge clk);
    #1;
    driveInputs(r, busy, s);
    expQ.push_back(e);
  endtask

  task automatic cmp(input string cyc, input string field, input logic [1:0] act,
                     input logic [1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s.%s got=%0d want=%0d", cyc, field, act, req);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    cmp(e.name, "pc_sel",   hif.pc_sel,   e.pc);
    cmp(e.name, "reg1_sel", hif.reg1_sel, e.r1);
    cmp(e.name, "reg2_sel", hif.reg2_sel, e.r2);
    cmp(e.name, "wb_sel",   hif.wb_sel,   e.wb);
    cmp(e.name, "pc_stall", {1'b0, hif.pc_stall}, {1'b0, e.st});
    cmp(e.name, "ex_kill",  {1'b0, hif.ex_kill},  {1'b0, e.exk});
    cmp(e.name, "wb_kill",  {1'b0, hif.wb_kill},  {1'b0, e.wbk});
  endtask

  // Monitor: outputs are combinational, so they are settled by the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expQ.size() != 0) begin
        e = expQ.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    stim_t nop, add8, jal1, add10, beqLu, lw12b, add13;
    nop   = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add8  = mk(1, 7, 1, 0, 1, 0, 0, 8, 1, 0, 0, 0, 1);
    jal1  = mk(1, 0, 0, 0, 0, 1, 1, 1, 1, 0, 1, 0, 3);
    add10 = mk(1, 9, 1, 9, 1, 0, 0, 10, 1, 0, 0, 0, 1);
    beqLu = mk(1, 11, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0);
    lw12b = mk(1, 12, 1, 0, 0, 0, 1, 12, 1, 1, 0, 0, 2);
    add13 = mk(1, 12, 1, 0, 1, 0, 0, 13, 1, 0, 0, 0, 1);
    driveInputs(1'b1, 1'b0, nop);

    applyStimulus(1, 0, nop, ex("reset", 0, 0, 0, 0, 0, 1, 0));
    applyStimulus(0, 0, nop, ex("post_reset", 0, 0, 0, 0, 0, 1, 0));
    applyStimulus(0, 0, mk(1, 0, 1, 0, 0, 0, 1, 5, 1, 0, 0, 0, 1),
                  ex("addi_x5", 0, 0, 2, 0, 0, 0, 0));
    applyStimulus(0, 0, mk(1, 5, 1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 1),
                  ex("fwd_both", 0, 1, 1, 1, 0, 0, 0));
    applyStimulus(0, 0, mk(1, 6, 1, 0, 0, 0, 1, 7, 1, 1, 0, 0, 2),
                  ex("lw_x7", 0, 1, 2, 1, 0, 0, 0));
    applyStimulus(0, 0, add8, ex("lu_stall", 0, 0, 0, 2, 1, 0, 1));
    applyStimulus(0, 0, add8, ex("lu_bubble", 0, 0, 0, 0, 0, 0, 0));
    applyStimulus(0, 0, mk(1, 0, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 1),
                  ex("addi_x0", 0, 0, 2, 1, 0, 0, 0));
    applyStimulus(0, 0, mk(1, 0, 1, 0, 1, 0, 0, 1, 1, 0, 0, 0, 1),
                  ex("x0_nofwd", 0, 0, 0, 1, 0, 0, 0));
    applyStimulus(0, 0, mk(1, 1, 1, 2, 1, 0, 0, 0, 0, 0, 0, 1, 0),
                  ex("beq_taken", 2, 1, 0, 1, 0, 1, 0));
    applyStimulus(0, 0, nop, ex("beq_after", 0, 0, 0, 0, 0, 0, 0));
    applyStimulus(0, 0, jal1, ex("jal", 1, 2, 2, 0, 0, 1, 0));
    applyStimulus(0, 0, nop, ex("jal_after", 0, 0, 0, 3, 0, 0, 0));
    applyStimulus(0, 0, mk(1, 0, 1, 0, 0, 0, 1, 9, 1, 1, 0, 0, 2),
                  ex("lw_x9", 0, 0, 2, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++)
      applyStimulus(0, 1, add10, ex("busy_hold", 0, 0, 0, 2, 1, 0, 0));
    applyStimulus(0, 0, add10, ex("busy_release", 0, 0, 0, 2, 1, 0, 1));
    applyStimulus(0, 0, add10, ex("busy_bubble", 0, 0, 0, 0, 0, 0, 0));
    applyStimulus(0, 0, mk(1, 10, 1, 0, 0, 0, 1, 11, 1, 1, 0, 0, 2),
                  ex("lw_x11", 0, 1, 2, 1, 0, 0, 0));
    applyStimulus(0, 0, beqLu, ex("br_lu_victim", 0, 0, 0, 2, 1, 0, 1));
    applyStimulus(1, 0, beqLu, ex("rst_in_stall", 0, 0, 0, 0, 0, 1, 0));
    applyStimulus(0, 0, nop, ex("rst_after", 0, 0, 0, 0, 0, 1, 0));
    applyStimulus(0, 0, jal1, ex("run_after_rst", 1, 2, 2, 0, 0, 1, 0));
    applyStimulus(0, 0, mk(1, 0, 1, 0, 0, 0, 1, 12, 1, 1, 0, 0, 2),
                  ex("lw_x12_a", 0, 0, 2, 3, 0, 0, 0));
    applyStimulus(0, 0, lw12b, ex("lw_x12_b", 0, 0, 2, 2, 1, 0, 1));
    applyStimulus(0, 0, lw12b, ex("lw_b_bubble", 0, 0, 0, 0, 0, 0, 0));
    applyStimulus(0, 0, add13, ex("lu_again", 0, 0, 0, 2, 1, 0, 1));
    applyStimulus(0, 0, add13, ex("lu_again_bubble", 0, 0, 0, 0, 0, 0, 0));
    applyStimulus(0, 0, nop, ex("drain", 0, 0, 0, 1, 0, 0, 0));

    repeat (3) @(posedge clk);
    total++;
    if (expQ.size() != 0) begin
      bad++;
      $display("[TB] FAIL scoreboard_drain got=%0d want=0 pending", expQ.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
